toy_lsu_mem_arb: RTL and testbench

TOY_LSU_MEM_ARB -- requirements
Module: toy_lsu_mem_arb

---
 rtl/toy_pack.sv | 68 ++++++
 rtl/toy_lsu_trk_fifo.sv | 69 ++++++
 rtl/toy_lsu_mem_arb.sv | 201 ++++++++++++++++++++
 tb/tb_toy_lsu_mem_arb.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/toy_pack.sv
// Shared types and constants for the toy load/store unit memory arbiter.
// Holds bus payload structs, tracker entry layout and load extension helper.
package toy_pack;

    localparam int ADDR_WIDTH    = 32;
    localparam int REG_WIDTH     = 32;
    localparam int LSID_WIDTH    = 4;
    localparam int RD_WIDTH      = 5;
    localparam int INST_ID_WIDTH = 4;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic TOY_BUS_READ  = 1'b0;
    localparam logic TOY_BUS_WRITE = 1'b1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]    mem_req_addr;
        logic [3:0]               mem_req_strb;
        logic [2:0]               funct3;
        logic [RD_WIDTH-1:0]      inst_rd;
        logic                     inst_fp_rd_en;
        logic [INST_ID_WIDTH-1:0] inst_id;
        logic [LSID_WIDTH-1:0]    lsid;
    } ldu_pkg;

    typedef struct packed {
        logic                  opcode;
        logic [ADDR_WIDTH-1:0] addr;
        logic [REG_WIDTH-1:0]  data;
        logic [3:0]            strb;
    } mem_req_pkg;

    typedef struct packed {
        logic [RD_WIDTH-1:0]      rd;
        logic                     fp_rd_en;
        logic [INST_ID_WIDTH-1:0] inst_id;
        logic [LSID_WIDTH-1:0]    lsid;
        logic [REG_WIDTH-1:0]     data;
    } ld_wb_pkg;

    typedef struct packed {
        logic                     is_load;
        logic [2:0]               funct3;
        logic [1:0]               off;
        logic [RD_WIDTH-1:0]      rd;
        logic                     fp_rd_en;
        logic [INST_ID_WIDTH-1:0] inst_id;
        logic [LSID_WIDTH-1:0]    lsid;
    } trk_entry_t;

    function automatic logic [REG_WIDTH-1:0] load_extend(
        input logic [2:0]           f3,
        input logic [REG_WIDTH-1:0] w
    );
        case (f3)
            F3_LB:   return {{(REG_WIDTH-8){w[7]}}, w[7:0]};
            F3_LBU:  return {{(REG_WIDTH-8){1'b0}}, w[7:0]};
            F3_LH:   return {{(REG_WIDTH-16){w[15]}}, w[15:0]};
            F3_LHU:  return {{(REG_WIDTH-16){1'b0}}, w[15:0]};
            default: return w;
        endcase
    endfunction

endpackage

// File: rtl/toy_lsu_trk_fifo.sv
// In-order tracker FIFO for outstanding memory requests.
// Push and pop in the same cycle keep the count unchanged.
module toy_lsu_trk_fifo
    import toy_pack::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  trk_entry_t               din,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output trk_entry_t               head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    trk_entry_t        mem_q [DEPTH];
    trk_entry_t        mem_d [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              push_ok, pop_ok;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign head    = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/toy_lsu_mem_arb.sv
// Round-robin load/store arbiter onto a single in-order memory port.
// Define TOY_LSU_ARB_PERF_EN to add saturating grant/stall counters.
module toy_lsu_mem_arb
    import toy_pack::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_ld_vld,
    output logic                  s_ld_rdy,
    input  ldu_pkg                s_ld_pld,
    input  logic                  s_st_vld,
    output logic                  s_st_rdy,
    input  logic [ADDR_WIDTH-1:0] s_st_addr,
    input  logic [REG_WIDTH-1:0]  s_st_data,
    input  logic [3:0]            s_st_strb,
    input  logic [LSID_WIDTH-1:0] s_st_lsid,
    output logic                  m_mem_req_vld,
    input  logic                  m_mem_req_rdy,
    output mem_req_pkg            m_mem_req_pld,
    input  logic                  s_mem_ack_vld,
    input  logic [REG_WIDTH-1:0]  s_mem_ack_data,
    output logic                  m_ld_wb_vld,
    output ld_wb_pkg              m_ld_wb_pld,
    output logic                  m_st_done_vld,
    output logic [LSID_WIDTH-1:0] m_st_done_lsid,
`ifdef TOY_LSU_ARB_PERF_EN
    output logic [31:0]           perf_ld_grant_cnt,
    output logic [31:0]           perf_st_grant_cnt,
    output logic [31:0]           perf_full_stall_cnt,
`endif
    output logic                  err_sticky
);

    localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

    logic                  slot_vld_q, slot_vld_d;
    mem_req_pkg            slot_q, slot_d;
    logic                  rr_st_q, rr_st_d;
    logic                  err_q, err_d;
    logic                  ld_wb_vld_q, ld_wb_vld_d;
    ld_wb_pkg              ld_wb_q, ld_wb_d;
    logic                  st_done_vld_q, st_done_vld_d;
    logic [LSID_WIDTH-1:0] st_done_lsid_q, st_done_lsid_d;

    logic                  can_take, ld_acc, st_acc, acc;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [3:0]            req_strb;
    logic [1:0]            req_off;
    logic [6:0]            strb_sh;
    trk_entry_t            trk_din, trk_head;
    logic                  trk_full, trk_empty, trk_pop;
    logic [CW-1:0]         trk_count;
    logic                  trk_count_unused;

    assign trk_count_unused = ^trk_count;

    // Credit check uses this cycle's count: a same-cycle ack frees nothing yet.
    always_comb begin
        can_take = rst_n && (!slot_vld_q || m_mem_req_rdy) && !trk_full;
        s_ld_rdy = can_take && (!s_st_vld || !rr_st_q);
        s_st_rdy = can_take && (!s_ld_vld || rr_st_q);
    end

    assign ld_acc   = s_ld_vld && s_ld_rdy;
    assign st_acc   = s_st_vld && s_st_rdy;
    assign acc      = ld_acc || st_acc;
    assign req_addr = ld_acc ? s_ld_pld.mem_req_addr : s_st_addr;
    assign req_strb = ld_acc ? s_ld_pld.mem_req_strb : s_st_strb;
    assign req_off  = req_addr[1:0];
    assign strb_sh  = {3'b000, req_strb} << req_off;
    assign trk_pop  = s_mem_ack_vld && !trk_empty;

    always_comb begin
        trk_din          = '0;
        trk_din.is_load  = ld_acc;
        trk_din.off      = req_off;
        trk_din.lsid     = ld_acc ? s_ld_pld.lsid : s_st_lsid;
        if (ld_acc) begin
            trk_din.funct3   = s_ld_pld.funct3;
            trk_din.rd       = s_ld_pld.inst_rd;
            trk_din.fp_rd_en = s_ld_pld.inst_fp_rd_en;
            trk_din.inst_id  = s_ld_pld.inst_id;
        end
    end

    always_comb begin
        slot_vld_d = slot_vld_q;
        slot_d     = slot_q;
        rr_st_d    = rr_st_q;
        if (acc) begin
            slot_vld_d    = 1'b1;
            slot_d.opcode = ld_acc ? TOY_BUS_READ : TOY_BUS_WRITE;
            slot_d.addr   = {req_addr[ADDR_WIDTH-1:2], 2'b00};
            slot_d.strb   = strb_sh[3:0];
            slot_d.data   = ld_acc ? '0 : (s_st_data << {req_off, 3'b000});
            rr_st_d       = ld_acc;
        end else if (m_mem_req_rdy) begin
            slot_vld_d = 1'b0;
        end
    end

    always_comb begin
        ld_wb_vld_d    = trk_pop && trk_head.is_load;
        st_done_vld_d  = trk_pop && !trk_head.is_load;
        ld_wb_d        = ld_wb_q;
        st_done_lsid_d = st_done_lsid_q;
        if (ld_wb_vld_d) begin
            ld_wb_d.rd       = trk_head.rd;
            ld_wb_d.fp_rd_en = trk_head.fp_rd_en;
            ld_wb_d.inst_id  = trk_head.inst_id;
            ld_wb_d.lsid     = trk_head.lsid;
            ld_wb_d.data     = load_extend(trk_head.funct3,
                s_mem_ack_data >> {trk_head.off, 3'b000});
        end
        if (st_done_vld_d) begin
            st_done_lsid_d = trk_head.lsid;
        end
        err_d = err_q || (acc && |strb_sh[6:4])
              || (s_mem_ack_vld && trk_empty);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_vld_q     <= 1'b0;
            slot_q         <= '0;
            rr_st_q        <= 1'b0;
            err_q          <= 1'b0;
            ld_wb_vld_q    <= 1'b0;
            ld_wb_q        <= '0;
            st_done_vld_q  <= 1'b0;
            st_done_lsid_q <= '0;
        end else begin
            slot_vld_q     <= slot_vld_d;
            slot_q         <= slot_d;
            rr_st_q        <= rr_st_d;
            err_q          <= err_d;
            ld_wb_vld_q    <= ld_wb_vld_d;
            ld_wb_q        <= ld_wb_d;
            st_done_vld_q  <= st_done_vld_d;
            st_done_lsid_q <= st_done_lsid_d;
        end
    end

    toy_lsu_trk_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_trk (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (acc),
        .pop   (trk_pop),
        .din   (trk_din),
        .full  (trk_full),
        .empty (trk_empty),
        .count (trk_count),
        .head  (trk_head)
    );

    assign m_mem_req_vld  = slot_vld_q;
    assign m_mem_req_pld  = slot_q;
    assign m_ld_wb_vld    = ld_wb_vld_q;
    assign m_ld_wb_pld    = ld_wb_q;
    assign m_st_done_vld  = st_done_vld_q;
    assign m_st_done_lsid = st_done_lsid_q;
    assign err_sticky     = err_q;

`ifdef TOY_LSU_ARB_PERF_EN
    logic [31:0] perf_ld_q, perf_ld_d;
    logic [31:0] perf_st_q, perf_st_d;
    logic [31:0] perf_fs_q, perf_fs_d;

    always_comb begin
        perf_ld_d = perf_ld_q;
        perf_st_d = perf_st_q;
        perf_fs_d = perf_fs_q;
        if (ld_acc && perf_ld_q != '1) perf_ld_d = perf_ld_q + 32'd1;
        if (st_acc && perf_st_q != '1) perf_st_d = perf_st_q + 32'd1;
        if ((s_ld_vld || s_st_vld) && trk_full && perf_fs_q != '1) begin
            perf_fs_d = perf_fs_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_ld_q <= '0;
            perf_st_q <= '0;
            perf_fs_q <= '0;
        end else begin
            perf_ld_q <= perf_ld_d;
            perf_st_q <= perf_st_d;
            perf_fs_q <= perf_fs_d;
        end
    end

    assign perf_ld_grant_cnt   = perf_ld_q;
    assign perf_st_grant_cnt   = perf_st_q;
    assign perf_full_stall_cnt = perf_fs_q;
`endif

endmodule

// File: tb/tb_toy_lsu_mem_arb.sv
// Randomized bench for toy_lsu_mem_arb against a queue-based reference model.
// Directed scenarios pin the model with hand-computed literal results.
module tb_toy_lsu_mem_arb;
    import toy_pack::*;

    localparam int MAXO = 4;
    localparam longint M32 = 64'hFFFF_FFFF;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  s_ld_vld, s_ld_rdy;
    ldu_pkg                s_ld_pld;
    logic                  s_st_vld, s_st_rdy;
    logic [ADDR_WIDTH-1:0] s_st_addr;
    logic [REG_WIDTH-1:0]  s_st_data;
    logic [3:0]            s_st_strb;
    logic [LSID_WIDTH-1:0] s_st_lsid;
    logic                  m_mem_req_vld, m_mem_req_rdy;
    mem_req_pkg            m_mem_req_pld;
    logic                  s_mem_ack_vld;
    logic [REG_WIDTH-1:0]  s_mem_ack_data;
    logic                  m_ld_wb_vld;
    ld_wb_pkg              m_ld_wb_pld;
    logic                  m_st_done_vld;
    logic [LSID_WIDTH-1:0] m_st_done_lsid;
    logic                  err_sticky;

    always #5 clk = ~clk;

    toy_lsu_mem_arb #(.MAX_OUTSTANDING(MAXO)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .s_ld_vld       (s_ld_vld),
        .s_ld_rdy       (s_ld_rdy),
        .s_ld_pld       (s_ld_pld),
        .s_st_vld       (s_st_vld),
        .s_st_rdy       (s_st_rdy),
        .s_st_addr      (s_st_addr),
        .s_st_data      (s_st_data),
        .s_st_strb      (s_st_strb),
        .s_st_lsid      (s_st_lsid),
        .m_mem_req_vld  (m_mem_req_vld),
        .m_mem_req_rdy  (m_mem_req_rdy),
        .m_mem_req_pld  (m_mem_req_pld),
        .s_mem_ack_vld  (s_mem_ack_vld),
        .s_mem_ack_data (s_mem_ack_data),
        .m_ld_wb_vld    (m_ld_wb_vld),
        .m_ld_wb_pld    (m_ld_wb_pld),
        .m_st_done_vld  (m_st_done_vld),
        .m_st_done_lsid (m_st_done_lsid),
        .err_sticky     (err_sticky)
    );

    typedef struct {
        bit ld; int f3; int off; int rd; bit fp; int id; int lsid;
    } ent_t;

    int     n_vec = 0;
    int     n_bad = 0;
    ent_t   mq[$];
    bit     m_slot_v, m_st_next, m_err, m_wb_v, m_sd_v;
    longint m_op, m_addr, m_data, m_strb, m_wb_data;
    int     m_wb_rd, m_wb_id, m_wb_lsid, m_sd_lsid;
    bit     m_wb_fp;
    bit     g_ld, g_st;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic longint ext(int f3, longint w);
        case (f3)
            0: return (w & 64'h80) != 0 ? ((w & 64'hFF) | 64'hFFFF_FF00) : (w & 64'hFF);
            4: return w & 64'hFF;
            1: return (w & 64'h8000) != 0 ? ((w & 64'hFFFF) | 64'hFFFF_0000) : (w & 64'hFFFF);
            5: return w & 64'hFFFF;
            default: return w;
        endcase
    endfunction

    function automatic void model_clear();
        mq.delete();
        m_slot_v = 0; m_st_next = 0; m_err = 0; m_wb_v = 0; m_sd_v = 0;
        m_op = 0; m_addr = 0; m_data = 0; m_strb = 0; m_wb_data = 0;
        m_wb_rd = 0; m_wb_id = 0; m_wb_lsid = 0; m_sd_lsid = 0; m_wb_fp = 0;
    endfunction

    // One clock: check outputs at negedge, predict, commit at posedge.
    task automatic step();
        bit e_can, e_ldr, e_str, ldacc, stacc;
        bit n_slot_v, n_st_next, n_err, n_wb_v, n_sd_v, n_wb_fp;
        longint n_op, n_addr, n_data, n_strb, n_wb_data, a, s, d;
        int n_wb_rd, n_wb_id, n_wb_lsid, n_sd_lsid, off;
        ent_t e;
        @(negedge clk);
        e_can = rst_n && (!m_slot_v || m_mem_req_rdy) && mq.size() < MAXO;
        e_ldr = e_can && (!s_st_vld || !m_st_next);
        e_str = e_can && (!s_ld_vld || m_st_next);
        chk("ld_rdy", s_ld_rdy, e_ldr);
        chk("st_rdy", s_st_rdy, e_str);
        chk("req_vld", m_mem_req_vld, m_slot_v);
        if (m_slot_v) begin
            chk("req_op", m_mem_req_pld.opcode, m_op);
            chk("req_addr", m_mem_req_pld.addr, m_addr);
            chk("req_data", m_mem_req_pld.data, m_data);
            chk("req_strb", m_mem_req_pld.strb, m_strb);
        end
        chk("err", err_sticky, m_err);
        chk("wb_vld", m_ld_wb_vld, m_wb_v);
        if (m_wb_v) begin
            chk("wb_data", m_ld_wb_pld.data, m_wb_data);
            chk("wb_rd", m_ld_wb_pld.rd, m_wb_rd);
            chk("wb_fp", m_ld_wb_pld.fp_rd_en, m_wb_fp);
            chk("wb_id", m_ld_wb_pld.inst_id, m_wb_id);
            chk("wb_lsid", m_ld_wb_pld.lsid, m_wb_lsid);
        end
        chk("sd_vld", m_st_done_vld, m_sd_v);
        if (m_sd_v) chk("sd_lsid", m_st_done_lsid, m_sd_lsid);
        g_ld = s_ld_vld && s_ld_rdy;
        g_st = s_st_vld && s_st_rdy;
        ldacc = s_ld_vld && e_ldr;
        stacc = s_st_vld && e_str;
        n_slot_v = m_slot_v; n_st_next = m_st_next; n_err = m_err;
        n_op = m_op; n_addr = m_addr; n_data = m_data; n_strb = m_strb;
        n_wb_v = 0; n_sd_v = 0; n_wb_data = m_wb_data; n_wb_rd = m_wb_rd;
        n_wb_id = m_wb_id; n_wb_lsid = m_wb_lsid; n_wb_fp = m_wb_fp;
        n_sd_lsid = m_sd_lsid;
        if (s_mem_ack_vld) begin
            if (mq.size() > 0) begin
                e = mq.pop_front();
                if (e.ld) begin
                    n_wb_v = 1;
                    n_wb_data = ext(e.f3, (longint'(s_mem_ack_data) >> (8 * e.off)) & M32);
                    n_wb_rd = e.rd; n_wb_fp = e.fp; n_wb_id = e.id; n_wb_lsid = e.lsid;
                end else begin
                    n_sd_v = 1; n_sd_lsid = e.lsid;
                end
            end else begin
                n_err = 1;
            end
        end
        if (ldacc || stacc) begin
            a = ldacc ? longint'(s_ld_pld.mem_req_addr) : longint'(s_st_addr);
            s = ldacc ? longint'(s_ld_pld.mem_req_strb) : longint'(s_st_strb);
            d = longint'(s_st_data);
            off = int'(a % 4);
            if ((s << off) > 15) n_err = 1;
            n_slot_v = 1;
            n_op = ldacc ? 0 : 1;
            n_addr = a - off;
            n_strb = (s << off) & 15;
            n_data = ldacc ? 0 : ((d << (8 * off)) & M32);
            e.ld = ldacc; e.off = off;
            e.f3 = ldacc ? int'(s_ld_pld.funct3) : 0;
            e.rd = ldacc ? int'(s_ld_pld.inst_rd) : 0;
            e.fp = ldacc ? s_ld_pld.inst_fp_rd_en : 1'b0;
            e.id = ldacc ? int'(s_ld_pld.inst_id) : 0;
            e.lsid = ldacc ? int'(s_ld_pld.lsid) : int'(s_st_lsid);
            mq.push_back(e);
            n_st_next = ldacc;
        end else if (m_mem_req_rdy) begin
            n_slot_v = 0;
        end
        @(posedge clk);
        if (!rst_n) begin
            model_clear();
        end else begin
            m_slot_v = n_slot_v; m_st_next = n_st_next; m_err = n_err;
            m_op = n_op; m_addr = n_addr; m_data = n_data; m_strb = n_strb;
            m_wb_v = n_wb_v; m_wb_data = n_wb_data; m_wb_rd = n_wb_rd;
            m_wb_fp = n_wb_fp; m_wb_id = n_wb_id; m_wb_lsid = n_wb_lsid;
            m_sd_v = n_sd_v; m_sd_lsid = n_sd_lsid;
        end
        #1;
    endtask

    task automatic idle();
        s_ld_vld = 0; s_st_vld = 0; s_mem_ack_vld = 0;
    endtask

    task automatic set_ld(logic [31:0] a, logic [3:0] sb, logic [2:0] f3,
                          logic [4:0] rd, logic [3:0] id, logic [3:0] ls);
        s_ld_vld = 1;
        s_ld_pld.mem_req_addr = a; s_ld_pld.mem_req_strb = sb;
        s_ld_pld.funct3 = f3; s_ld_pld.inst_rd = rd;
        s_ld_pld.inst_fp_rd_en = rd[0]; s_ld_pld.inst_id = id; s_ld_pld.lsid = ls;
    endtask

    task automatic set_st(logic [31:0] a, logic [31:0] d, logic [3:0] sb, logic [3:0] ls);
        s_st_vld = 1; s_st_addr = a; s_st_data = d; s_st_strb = sb; s_st_lsid = ls;
    endtask

    task automatic drain();
        idle();
        m_mem_req_rdy = 1;
        for (int i = 0; i < 40; i++) begin
            if (!m_slot_v && mq.size() == 0) break;
            s_mem_ack_vld = (mq.size() > 0);
            s_mem_ack_data = $urandom;
            step();
        end
        s_mem_ack_vld = 0;
        chk("drain_bound", (m_slot_v || mq.size() > 0), 0);
    endtask

    function automatic logic [3:0] rnd_strb(bit aligned, logic [1:0] off);
        int sz;
        if (!aligned) return 4'($urandom);
        sz = (off == 0) ? $urandom_range(0, 2) : (off == 2 ? $urandom_range(0, 1) : 0);
        return sz == 0 ? 4'h1 : (sz == 1 ? 4'h3 : 4'hF);
    endfunction

    task automatic rnd_inputs(bit aligned);
        logic [31:0] a;
        a = $urandom;
        if (aligned) a[1:0] = 2'($urandom_range(0, 1) * 2 * ($urandom_range(0, 1)));
        if (aligned && $urandom_range(0, 3) == 0) a[1:0] = 2'($urandom);
        set_ld(a, rnd_strb(aligned, a[1:0]), 3'($urandom), 5'($urandom),
               4'($urandom), 4'($urandom));
        s_ld_vld = $urandom_range(0, 1);
        a = $urandom;
        if (aligned) a[1:0] = 2'($urandom_range(0, 1) * 2);
        set_st(a, $urandom, rnd_strb(aligned, a[1:0]), 4'($urandom));
        s_st_vld = $urandom_range(0, 1);
        m_mem_req_rdy = ($urandom_range(0, 9) < 7);
        s_mem_ack_data = $urandom;
        s_mem_ack_vld = ($urandom_range(0, 9) < 4) && (!aligned || mq.size() > 0);
    endtask

    logic [3:0] seq;
    mem_req_pkg held;

    initial begin
        rst_n = 0; idle(); m_mem_req_rdy = 0; s_mem_ack_data = 0;
        s_ld_pld = '0; s_st_addr = 0; s_st_data = 0; s_st_strb = 0; s_st_lsid = 0;
        model_clear();
        step(); step();
        chk("reset_req_vld", m_mem_req_vld, 0);
        chk("reset_err", err_sticky, 0);
        rst_n = 1;
        step();

        set_ld(32'h1002, 4'h3, F3_LH, 5'd5, 4'd3, 4'd7);
        step();
        chk("lh_req_addr", m_mem_req_pld.addr, 32'h1000);
        chk("lh_req_strb", m_mem_req_pld.strb, 4'hC);
        chk("lh_req_op", m_mem_req_pld.opcode, TOY_BUS_READ);
        idle(); m_mem_req_rdy = 1; step();
        s_mem_ack_vld = 1; s_mem_ack_data = 32'h8001_0000; step();
        s_mem_ack_vld = 0;
        chk("lh_wb_vld", m_ld_wb_vld, 1);
        chk("lh_wb_data", m_ld_wb_pld.data, 32'hFFFF_8001);
        chk("lh_wb_rd", m_ld_wb_pld.rd, 5);
        step();

        m_mem_req_rdy = 0;
        set_st(32'h2003, 32'hAB, 4'h1, 4'd9);
        step();
        chk("sb_req_data", m_mem_req_pld.data, 32'hAB00_0000);
        chk("sb_req_strb", m_mem_req_pld.strb, 4'h8);
        chk("sb_req_op", m_mem_req_pld.opcode, TOY_BUS_WRITE);
        idle(); m_mem_req_rdy = 1; step();
        s_mem_ack_vld = 1; step();
        s_mem_ack_vld = 0;
        chk("sb_done_vld", m_st_done_vld, 1);
        chk("sb_done_lsid", m_st_done_lsid, 9);
        drain();

        seq = 0;
        set_ld(32'h3000, 4'hF, F3_LW, 5'd1, 4'd1, 4'd1);
        set_st(32'h4000, 32'h1234, 4'hF, 4'd2);
        for (int i = 0; i < 4; i++) begin
            s_mem_ack_vld = (mq.size() > 0);
            step();
            seq = {seq[2:0], g_ld};
        end
        chk("rr_seq", seq, 4'b1010);
        drain();

        set_ld(32'h5000, 4'hF, F3_LW, 5'd2, 4'd2, 4'd2);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("fill_grant", g_ld, 1);
        end
        step();
        chk("full_block", g_ld, 0);
        s_mem_ack_vld = 1; step();
        chk("ack_no_credit", g_ld, 0);
        s_mem_ack_vld = 0; step();
        chk("credit_next", g_ld, 1);
        drain();

        m_mem_req_rdy = 0;
        set_ld(32'h6004, 4'h1, F3_LBU, 5'd3, 4'd3, 4'd3);
        step();
        held = m_mem_req_pld;
        idle();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_vld", m_mem_req_vld, 1);
            chk("stall_pld", m_mem_req_pld == held, 1);
        end
        drain();
        chk("err_before_stray", err_sticky, 0);
        s_mem_ack_vld = 1; step();
        s_mem_ack_vld = 0;
        chk("stray_err", err_sticky, 1);
        chk("stray_wb", m_ld_wb_vld | m_st_done_vld, 0);

        m_mem_req_rdy = 1;
        set_ld(32'h7000, 4'hF, F3_LW, 5'd4, 4'd4, 4'd4);
        step(); step();
        idle(); rst_n = 0; step();
        chk("rst_req_vld", m_mem_req_vld, 0);
        chk("rst_req_pld", |m_mem_req_pld, 0);
        chk("rst_rdy", s_ld_rdy | s_st_rdy, 0);
        chk("rst_wb", m_ld_wb_vld | (|m_ld_wb_pld), 0);
        chk("rst_sd", m_st_done_vld | (|m_st_done_lsid), 0);
        chk("rst_err", err_sticky, 0);
        rst_n = 1; step();
        s_mem_ack_vld = 1; step();
        s_mem_ack_vld = 0;
        chk("post_rst_ack_err", err_sticky, 1);
        chk("post_rst_ack_wb", m_ld_wb_vld | m_st_done_vld, 0);

        rst_n = 0; step(); rst_n = 1;
        for (int i = 0; i < 3000; i++) begin
            rnd_inputs(1);
            step();
        end
        chk("aligned_no_err", err_sticky, 0);
        for (int i = 0; i < 3000; i++) begin
            rnd_inputs(0);
            rst_n = ($urandom_range(0, 49) != 0);
            step();
        end
        rst_n = 1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
